// File: rtl/ibuf_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong input buffer controller.
// Bank-state encoding and the helper that says whether the write side may use a bank.
package ibuf_pingpong_ctrl_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/ibuf_pingpong_ctrl_pp_bank_state.sv
// Per-bank lifecycle FSM (EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY) plus the fill length.
// Events for one bank are mutually exclusive by construction of the controller.
module pp_bank_state
    import ibuf_pingpong_ctrl_pkg::*;
#(
    parameter int ASIZE = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fill_first,
    input  logic           fill_last,
    input  logic           drain_start,
    input  logic           drain_done,
    input  logic [ASIZE:0] len_in,
    output bank_state_e    state,
    output logic [ASIZE:0] len
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BANK_EMPTY;
            len   <= '0;
        end else begin
            if (fill_first) begin
                len <= len_in;
            end
            // A one-word fill asserts first and last together and lands directly in FULL.
            if (fill_last) begin
                state <= BANK_FULL;
            end else if (fill_first) begin
                state <= BANK_FILLING;
            end
            if (drain_start) begin
                state <= BANK_DRAINING;
            end
            if (drain_done) begin
                state <= BANK_EMPTY;
            end
        end
    end

endmodule

// File: rtl/ibuf_pingpong_ctrl.sv
// Ping-pong controller for a two-bank input buffer held in an external dual-port RAM.
// Write handshake: a word transfers in any cycle where I_wvalid && O_wready; I_wvalid may not depend on O_wready.
module ibuf_pingpong_ctrl
    import ibuf_pingpong_ctrl_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int ASIZE = 10
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic [ASIZE:0]   I_wlen,
    input  logic             I_wvalid,
    input  logic [DSIZE-1:0] I_wdata,
    output logic             O_wready,
    output logic [ASIZE:0]   O_ram_waddr,
    output logic [DSIZE-1:0] O_ram_wdata,
    output logic             O_ram_wen,
    input  logic             I_rstart,
    output logic             O_rfull,
    output logic [ASIZE:0]   O_ram_raddr,
    output logic             O_ram_ren,
    input  logic [DSIZE-1:0] I_ram_rdata,
    output logic [DSIZE-1:0] O_rdata,
    output logic             O_rvalid,
    output logic             O_rlast,
    output logic             O_rdone,
    output logic [3:0]       O_bank_state
);

    logic             wbank;
    logic             rbank;
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic             ready_en;
    logic             issuing;
    logic             rvalid_q;
    logic             rlast_q;

    bank_state_e      bstate [2];
    logic [ASIZE:0]   blen   [2];

    logic             wacc;
    logic             wfirst;
    logic             wlast;
    logic [ASIZE:0]   wlen_eff;
    logic             rstart_ok;
    logic             rlast_addr;
    logic [1:0]       fill_first_v;
    logic [1:0]       fill_last_v;
    logic [1:0]       drain_start_v;
    logic [1:0]       drain_done_v;

    always_comb begin
        // ready_en holds O_wready low through reset and releases it one clock later.
        O_wready      = ready_en && bank_writable(bstate[wbank]);
        wacc          = I_wvalid && O_wready;
        wfirst        = wacc && (bstate[wbank] == BANK_EMPTY);
        wlen_eff      = wfirst ? I_wlen : blen[wbank];
        wlast         = wacc && ({1'b0, wptr} == (wlen_eff - (ASIZE+1)'(1)));
        O_rfull       = (bstate[rbank] == BANK_FULL);
        rstart_ok     = I_rstart && O_rfull && !issuing && !rlast_q;
        rlast_addr    = issuing && ({1'b0, rptr} == (blen[rbank] - (ASIZE+1)'(1)));

        fill_first_v  = wfirst     ? (wbank ? 2'b10 : 2'b01) : 2'b00;
        fill_last_v   = wlast      ? (wbank ? 2'b10 : 2'b01) : 2'b00;
        drain_start_v = rstart_ok  ? (rbank ? 2'b10 : 2'b01) : 2'b00;
        drain_done_v  = rlast_q    ? (rbank ? 2'b10 : 2'b01) : 2'b00;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pp_bank_state #(
            .ASIZE(ASIZE)
        ) u_bank (
            .clk        (I_clk),
            .rst        (I_rst),
            .fill_first (fill_first_v[g]),
            .fill_last  (fill_last_v[g]),
            .drain_start(drain_start_v[g]),
            .drain_done (drain_done_v[g]),
            .len_in     (I_wlen),
            .state      (bstate[g]),
            .len        (blen[g])
        );
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            ready_en <= 1'b0;
            wbank    <= 1'b0;
            wptr     <= '0;
            rbank    <= 1'b0;
            rptr     <= '0;
            issuing  <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (wacc) begin
                if (wlast) begin
                    wbank <= ~wbank;
                    wptr  <= '0;
                end else begin
                    wptr  <= wptr + 1'b1;
                end
            end

            // One address per cycle once a drain starts; no stall path exists.
            if (rstart_ok) begin
                issuing <= 1'b1;
                rptr    <= '0;
            end else if (issuing) begin
                if (rlast_addr) begin
                    issuing <= 1'b0;
                end else begin
                    rptr    <= rptr + 1'b1;
                end
            end

            rvalid_q <= issuing;
            rlast_q  <= rlast_addr;

            // The last word returns this cycle: release the bank and move to the other one.
            if (rlast_q) begin
                rbank <= ~rbank;
                rptr  <= '0;
            end
        end
    end

    assign O_ram_wen    = wacc;
    assign O_ram_waddr  = wacc ? {wbank, wptr} : '0;
    assign O_ram_wdata  = wacc ? I_wdata : '0;
    assign O_ram_ren    = issuing;
    assign O_ram_raddr  = issuing ? {rbank, rptr} : '0;
    assign O_rvalid     = rvalid_q;
    assign O_rdata      = rvalid_q ? I_ram_rdata : '0;
    assign O_rlast      = rlast_q;
    assign O_rdone      = rlast_q;
    assign O_bank_state = {bstate[1], bstate[0]};

endmodule

// File: doc/ibuf_pingpong_ctrl.md
IBUF_PINGPONG_CTRL -- requirements
Module: ibuf_pingpong_ctrl

Interface
REQ-001 The block SHALL have parameter DSIZE, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter ASIZE, default 10, meaning the per-bank address width; the buffer has two banks of 2^ASIZE words each.
REQ-003 The block SHALL have these ports:
- I_clk  in  1  sole clock.
- I_rst  in  1  reset, asynchronous, active-high.
- I_wlen  in  ASIZE+1  words per fill, 1..2^ASIZE; sampled on the first accepted word of a fill.
- I_wvalid  in  1  write word valid.
- I_wdata  in  DSIZE  write word.
- O_wready  out  1  write word accepted when I_wvalid && O_wready.
- O_ram_waddr  out  ASIZE+1  dual-port RAM port-0 address, {bank, ptr}.
- O_ram_wdata  out  DSIZE  port-0 write data.
- O_ram_wen  out  1  port-0 ce and wr.
- I_rstart  in  1  drain-request pulse.
- O_rfull  out  1  read bank is FULL, so a drain may start.
- O_ram_raddr  out  ASIZE+1  port-1 address, {bank, ptr}.
- O_ram_ren  out  1  port-1 ce.
- I_ram_rdata  in  DSIZE  port-1 read data, 1-cycle latency.
- O_rdata  out  DSIZE  drained word.
- O_rvalid  out  1  O_rdata valid.
- O_rlast  out  1  last word of the drain.
- O_rdone  out  1  one-cycle pulse, bank released.
- O_bank_state  out  4  {bank1 state, bank0 state}.

Function
REQ-004 Each bank SHALL hold one of four states: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
REQ-005 The write side SHALL track wbank and wptr; O_wready = 1 while bank[wbank] is EMPTY or FILLING.
REQ-006 On each accepted word, the block SHALL:
- drive O_ram_wen=1, O_ram_waddr={wbank,wptr} and O_ram_wdata=I_wdata in the same cycle (combinational);
- on the first word, set bank[wbank] to FILLING and store len[wbank]=I_wlen.
REQ-007 When the word at wptr==len[wbank]-1 is accepted, the block SHALL set bank[wbank] to FULL, toggle wbank and clear wptr; with I_wlen=1, a single word goes EMPTY to FULL.
REQ-008 The read side SHALL track rbank and rptr; O_rfull = (bank[rbank]==FULL).
REQ-009 I_rstart with O_rfull=1 SHALL set bank[rbank] to DRAINING; from the next cycle, one address SHALL issue per cycle with no stall:
- O_ram_ren=1;
- O_ram_raddr={rbank,rptr}, with rptr running 0..len[rbank]-1.
REQ-010 O_rvalid and O_rdata=I_ram_rdata SHALL follow each issued address by exactly 1 cycle; O_rlast SHALL accompany the final word.
REQ-011 In the cycle after the last address issues, the block SHALL:
- set bank[rbank] to EMPTY;
- toggle rbank and clear rptr;
- pulse O_rdone (coincident with O_rlast).
REQ-012 I_rstart SHALL be ignored when O_rfull=0 or a drain is in progress; it is not queued.
REQ-013 A fill completing on one bank and a drain releasing the other bank in the same cycle SHALL both take effect.
REQ-014 A bank released to EMPTY in cycle N SHALL be writable (O_wready=1) in cycle N+1 when it equals wbank.
REQ-015 wbank and rbank SHALL never address a bank in a state illegal for that side, i.e. no write into FULL/DRAINING and no read of EMPTY/FILLING.

Reset
REQ-016 While I_rst is high, the block SHALL asynchronously force:
- both banks EMPTY;
- wbank=rbank=0 and wptr=rptr=0;
- every output to 0, except that O_wready becomes 1 on the first clock after deassertion.
REQ-017 Reset mid-fill or mid-drain SHALL abandon the transfer with no further O_rvalid, O_rlast or O_rdone.

Structure
REQ-018 The bank-state encodings (EMPTY/FILLING/FULL/DRAINING) SHALL be defined in the shared cnna package/header.
REQ-019 Per-bank state and length SHALL be implemented in one sub-module, pp_bank_state, instantiated twice.
REQ-020 The block SHALL contain no memory; it drives an external dpram of depth 2^(ASIZE+1).

Verification
REQ-021 The bench SHALL cover:
- Basic fill: ASIZE=4, I_wlen=16, 16 words 0..15 -> bank0 FULL, wbank=1, O_rfull=1.
- Basic drain: I_rstart -> raddr 0..15 on consecutive cycles; O_rdata 0..15, O_rlast on 15, O_rdone once, bank0 EMPTY.
- Ping-pong overlap: fill bank1 (I_wlen=3) while draining bank0 -> no write stall; both banks end as expected.
- Backpressure: both banks FULL -> O_wready=0 until the first O_rdone, then 1 on the next cycle.
- Boundaries: I_wlen=1 -> single-word fill and drain; I_rstart while EMPTY -> ignored; I_rstart during a drain -> ignored.
- Reset at word 7 of a 16-word drain -> outputs 0, both banks EMPTY, no O_rdone.
